// File: rtl/demux_stream_n.sv
// demux_stream_n: registered 1:N valid/ready stream demultiplexer.
// Each output channel owns a one-entry register. An optional burst lock
// keeps the route chosen on the first beat of a burst until its last beat.
// Beats aimed at a channel index that does not exist are counted and discarded.
module demux_stream_n #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 8,
    parameter int SEL_W      = $clog2(CHANNELS),
    parameter int LOCK_BURST = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Enable,
    input  logic [WIDTH-1:0]          InData,
    input  logic                      InValid,
    input  logic                      InLast,
    output logic                      InReady,
    input  logic [SEL_W-1:0]          Sel,
    output logic [CHANNELS*WIDTH-1:0] OutData,
    output logic [CHANNELS-1:0]       OutValid,
    output logic [CHANNELS-1:0]       OutLast,
    input  logic [CHANNELS-1:0]       OutReady,
    output logic [15:0]               DropCount,
    output logic                      Busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [SEL_W-1:0]      latched_sel;
    logic [SEL_W-1:0]      tgt;
    logic [CHANNELS-1:0]   hit;
    logic [CHANNELS-1:0]   load;
    logic                  tgt_ok;
    logic                  tgt_full;
    logic                  accept;
    logic [15:0]           drop_cnt;

    logic [WIDTH-1:0]      data_p1 [CHANNELS];
    logic [CHANNELS-1:0]   last_p1;
    logic [CHANNELS-1:0]   vld_p1;

    // Saturating +1 for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Decode the target channel and decide whether the input beat can be taken.
    // An out-of-range index decodes to no channel, so it is never blocked.
    always_comb begin
        tgt      = (LOCK_BURST != 0 && state == BURST) ? latched_sel : Sel;
        hit      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k] = (int'(tgt) == k);
        end
        tgt_ok   = |hit;
        tgt_full = |(hit & vld_p1 & ~OutReady);
        InReady  = Enable && !tgt_full;
        accept   = InValid && InReady;
        load     = accept ? hit : '0;
    end

    // ---- stage p1: per-channel output registers ----
    // Load on accept (also when draining in the same cycle), otherwise clear
    // valid once the consumer has taken the beat.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p1  <= '0;
            last_p1 <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    data_p1[k] <= InData;
                    last_p1[k] <= InLast;
                    vld_p1[k]  <= 1'b1;
                end else if (vld_p1[k] && OutReady[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
        end
    end

    // Burst-lock state machine and drop counter; both advance only on accepted beats.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            latched_sel <= '0;
            drop_cnt    <= '0;
        end else begin
            if (accept && !tgt_ok) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end
            if (LOCK_BURST != 0 && accept) begin
                case (state)
                    IDLE: begin
                        if (!InLast) begin
                            latched_sel <= Sel;
                            state       <= BURST;
                        end
                    end
                    BURST: begin
                        if (InLast) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_out
        assign OutData[k*WIDTH +: WIDTH] = data_p1[k];
    end

    assign OutValid  = vld_p1;
    assign OutLast   = last_p1;
    assign DropCount = drop_cnt;
    assign Busy      = (state == BURST);

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: an 8-channel instance for routing, backpressure,
// burst lock and enable/reset, and a 6-channel instance for out-of-range drops.
module tb_demux_stream_n;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic [7:0]  InData;
    logic        InValid;
    logic        InLast;
    logic        InReady;
    logic [2:0]  Sel;
    logic [63:0] OutData;
    logic [7:0]  OutValid;
    logic [7:0]  OutLast;
    logic [7:0]  OutReady;
    logic [15:0] DropCount;
    logic        Busy;

    logic        Enable6;
    logic [7:0]  InData6;
    logic        InValid6;
    logic        InLast6;
    logic        InReady6;
    logic [2:0]  Sel6;
    logic [47:0] OutData6;
    logic [5:0]  OutValid6;
    logic [5:0]  OutLast6;
    logic [5:0]  OutReady6;
    logic [15:0] DropCount6;
    logic        Busy6;

    exp_t sb[$];
    int   total;
    int   bad;

    demux_stream_n #(.WIDTH(8), .CHANNELS(8), .LOCK_BURST(1)) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .InData(InData), .InValid(InValid),
        .InLast(InLast), .InReady(InReady), .Sel(Sel), .OutData(OutData),
        .OutValid(OutValid), .OutLast(OutLast), .OutReady(OutReady),
        .DropCount(DropCount), .Busy(Busy)
    );

    demux_stream_n #(.WIDTH(8), .CHANNELS(6), .LOCK_BURST(1)) dut6 (
        .Clk(Clk), .Rst(Rst), .Enable(Enable6), .InData(InData6), .InValid(InValid6),
        .InLast(InLast6), .InReady(InReady6), .Sel(Sel6), .OutData(OutData6),
        .OutValid(OutValid6), .OutLast(OutLast6), .OutReady(OutReady6),
        .DropCount(DropCount6), .Busy(Busy6)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Scoreboard consumer: every handshake seen on the 8-channel outputs pops one expected beat.
    task automatic run_monitor();
        exp_t e;
        exp_t got;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                for (int k = 0; k < 8; k++) begin
                    if (OutValid[k] && OutReady[k]) begin
                        got = {3'(k), OutData[k*8 +: 8], OutLast[k]};
                        total++;
                        if (sb.size() == 0) begin
                            bad++;
                            $display("FAIL mon_unexpected got ch=%0d d=%h l=%b required none", k, got.d, got.l);
                        end else begin
                            e = sb.pop_front();
                            if (got !== e) begin
                                bad++;
                                $display("FAIL mon_beat got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b",
                                         got.ch, got.d, got.l, e.ch, e.d, e.l);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Present one beat, wait (bounded) for InReady, record expectation; ends at posedge+1.
    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic l,
                        input int exp_ch, output int waits);
        waits   = 0;
        InData  = d;
        Sel     = s;
        InLast  = l;
        InValid = 1'b1;
        @(negedge Clk);
        while (!InReady && waits < 20) begin
            @(negedge Clk);
            waits++;
        end
        total++;
        if (!InReady) begin
            bad++;
            $display("FAIL send_timeout got InReady=0 required 1 d=%h", d);
        end else if (exp_ch >= 0) begin
            sb.push_back({3'(exp_ch), d, l});
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        total++; if (OutValid !== 8'h00) begin bad++; $display("FAIL rst_valid got %h required 00", OutValid); end
        total++; if (OutLast !== 8'h00) begin bad++; $display("FAIL rst_last got %h required 00", OutLast); end
        total++; if (OutData !== 64'h0) begin bad++; $display("FAIL rst_data got %h required 0", OutData); end
        total++; if (DropCount !== 16'h0) begin bad++; $display("FAIL rst_drop got %0d required 0", DropCount); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", Busy); end
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL rst_ready_disabled got %b required 0", InReady); end
        total++; if (DropCount6 !== 16'h0) begin bad++; $display("FAIL rst_drop6 got %0d required 0", DropCount6); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_single();
        int w;
        Enable   = 1'b1;
        OutReady = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            send(8'hA0 + 8'(k), 3'(k), 1'b1, k, w);
            total++; if (w != 0) begin bad++; $display("FAIL single_ready ch=%0d got waits=%0d required 0", k, w); end
            total++; if (OutValid !== (8'b1 << k)) begin bad++; $display("FAIL single_valid ch=%0d got %h required %h", k, OutValid, 8'b1 << k); end
            total++; if (OutData[k*8 +: 8] !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL single_data ch=%0d got %h required %h", k, OutData[k*8 +: 8], 8'hA0 + 8'(k)); end
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL single_busy ch=%0d got %b required 0", k, Busy); end
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int w;
        OutReady[3] = 1'b0;
        send(8'h31, 3'd3, 1'b1, 3, w);
        InData  = 8'h32;
        Sel     = 3'd3;
        InLast  = 1'b1;
        InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++; if (InReady !== 1'b0) begin bad++; $display("FAIL bp_ready got %b required 0", InReady); end
            total++; if (OutValid[3] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got %b required 1", OutValid[3]); end
            total++; if (OutData[24 +: 8] !== 8'h31) begin bad++; $display("FAIL bp_hold_data got %h required 31", OutData[24 +: 8]); end
        end
        @(posedge Clk);
        #1;
        OutReady[3] = 1'b1;
        sb.push_back({3'd3, 8'h32, 1'b1});
        @(negedge Clk);
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b required 1", InReady); end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        total++; if (OutValid[3] !== 1'b1 || OutData[24 +: 8] !== 8'h32) begin
            bad++; $display("FAIL bp_reload got v=%b d=%h required v=1 d=32", OutValid[3], OutData[24 +: 8]);
        end
        @(posedge Clk);
        #1;
        total++; if (OutValid !== 8'h00) begin bad++; $display("FAIL bp_drained got %h required 00", OutValid); end
    endtask

    task automatic test_burst();
        int w;
        send(8'h50, 3'd5, 1'b0, 5, w);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL burst_busy0 got %b required 1", Busy); end
        send(8'h51, 3'd2, 1'b0, 5, w);
        send(8'h52, 3'd2, 1'b0, 5, w);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL burst_busy2 got %b required 1", Busy); end
        send(8'h53, 3'd2, 1'b1, 5, w);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL burst_busy_end got %b required 0", Busy); end
        send(8'h20, 3'd2, 1'b1, 2, w);
        total++; if (OutValid !== 8'h04) begin bad++; $display("FAIL burst_after_route got %h required 04", OutValid); end
        idle(2);
    endtask

    task automatic test_drop();
        Enable6   = 1'b1;
        OutReady6 = 6'h3F;
        InData6   = 8'h77;
        Sel6      = 3'd7;
        InValid6  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InLast6 = (i == 2);
            @(negedge Clk);
            total++; if (InReady6 !== 1'b1) begin bad++; $display("FAIL drop_ready beat=%0d got %b required 1", i, InReady6); end
            total++; if (OutValid6 !== 6'h00) begin bad++; $display("FAIL drop_valid beat=%0d got %h required 00", i, OutValid6); end
            @(posedge Clk);
            #1;
            if (i == 0) begin
                total++; if (Busy6 !== 1'b1) begin bad++; $display("FAIL drop_busy got %b required 1", Busy6); end
            end
        end
        InValid6 = 1'b0;
        total++; if (DropCount6 !== 16'd3) begin bad++; $display("FAIL drop_count got %0d required 3", DropCount6); end
        total++; if (Busy6 !== 1'b0) begin bad++; $display("FAIL drop_busy_end got %b required 0", Busy6); end
        @(negedge Clk);
        total++; if (OutValid6 !== 6'h00) begin bad++; $display("FAIL drop_valid_end got %h required 00", OutValid6); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_enable_reset();
        int w;
        OutReady[1] = 1'b0;
        send(8'h60, 3'd1, 1'b0, 1, w);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL en_busy got %b required 1", Busy); end
        Enable  = 1'b0;
        InData  = 8'h61;
        Sel     = 3'd1;
        InLast  = 1'b0;
        InValid = 1'b1;
        @(negedge Clk);
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL en_ready_off got %b required 0", InReady); end
        @(posedge Clk);
        #1;
        OutReady[1] = 1'b1;
        @(negedge Clk);
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL en_ready_off2 got %b required 0", InReady); end
        @(posedge Clk);
        #1;
        total++; if (OutValid[1] !== 1'b0) begin bad++; $display("FAIL en_drain got %b required 0", OutValid[1]); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL en_busy_hold got %b required 1", Busy); end
        InValid = 1'b0;
        Enable  = 1'b1;
        Rst     = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        total++; if (OutValid !== 8'h00 || OutLast !== 8'h00 || OutData !== 64'h0) begin
            bad++; $display("FAIL mid_rst_outputs got v=%h l=%h d=%h required all 0", OutValid, OutLast, OutData);
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b required 0", Busy); end
        total++; if (DropCount6 !== 16'h0) begin bad++; $display("FAIL mid_rst_drop6 got %0d required 0", DropCount6); end
        send(8'h70, 3'd4, 1'b1, 4, w);
        total++; if (OutValid !== 8'h10 || OutData[32 +: 8] !== 8'h70) begin
            bad++; $display("FAIL mid_rst_live_sel got v=%h d=%h required v=10 d=70", OutValid, OutData[32 +: 8]);
        end
        idle(3);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        Rst       = 1'b1;
        Enable    = 1'b0;
        InData    = 8'h00;
        InValid   = 1'b0;
        InLast    = 1'b0;
        Sel       = 3'd0;
        OutReady  = 8'h00;
        Enable6   = 1'b0;
        InData6   = 8'h00;
        InValid6  = 1'b0;
        InLast6   = 1'b0;
        Sel6      = 3'd0;
        OutReady6 = 6'h00;
        fork
            run_monitor();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_drop();
        test_enable_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_empty got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
- Parametrised, registered 1:N stream demultiplexer; successor to the fixed 1:8 combinational enable-gated demux.
- Routes WIDTH-bit beats from one valid/ready input to one of CHANNELS valid/ready outputs, each with a one-entry output register.
- Optional burst lock: Sel is latched on the first beat of a burst and held until the InLast beat.
- Sits between a single producer and N independent consumers; it is the fan-out stage of the datapath.

Parameters:
- WIDTH, 8, data bits per beat.
- CHANNELS, 8, number of output channels (2..64).
- SEL_W, $clog2(CHANNELS), Sel width. Derived; do not override.
- LOCK_BURST, 1, 1 = hold the route from the first beat until InLast; 0 = sample Sel on every beat.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Enable  in  1  global accept enable; does not stop draining
- InData  in  WIDTH  input beat
- InValid  in  1  input beat valid
- InLast  in  1  last beat of burst
- InReady  out  1  block can accept a beat
- Sel  in  SEL_W  destination channel index
- OutData  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- OutValid  out  CHANNELS  per-channel valid
- OutLast  out  CHANNELS  per-channel last flag
- OutReady  in  CHANNELS  per-channel ready
- DropCount  out  16  beats discarded for out-of-range Sel; saturating
- Busy  out  1  1 while in BURST state

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - OutValid=0, OutLast=0, OutData=0, DropCount=0, state=IDLE, Busy=0.
  - Any in-flight beat or partial burst is discarded; no flush is performed.
- Target selection:
  - tgt = latched_sel when state=BURST, otherwise Sel.
  - With LOCK_BURST=0, tgt = Sel always and the state machine stays in IDLE.
- Range check: tgt_ok = (tgt < CHANNELS). Only relevant when CHANNELS is not a power of two.
- Accept logic:
  - InReady = Enable && (!tgt_ok || !OutValid[tgt] || OutReady[tgt]). Combinational; depends only on current inputs and state.
  - A beat is accepted when InValid && InReady.
- Accept, in range:
  - Next cycle OutData[tgt]=InData, OutLast[tgt]=InLast, OutValid[tgt]=1. Latency is 1 cycle.
- Accept, out of range:
  - The beat is dropped and DropCount increments, saturating at 16'hFFFF.
  - The burst state machine still advances.
- Channel drain:
  - If OutValid[k] && OutReady[k] and there is no new beat for channel k, then OutValid[k]=0 next cycle.
  - Simultaneous drain and load on the same channel reloads the register, giving full throughput of 1 beat/cycle.
- Output stability: while OutValid[k]=1 && OutReady[k]=0, OutData and OutLast for channel k hold stable.
- Idle channels: channels other than tgt are unaffected by input activity and drain independently.
- State machine (LOCK_BURST=1):
  - IDLE: on an accepted beat with InLast=0, latch latched_sel=Sel and go to BURST. On an accepted beat with InLast=1, stay in IDLE (single-beat burst).
  - BURST: Sel is ignored. On an accepted beat with InLast=1, go to IDLE.
- Enable=0:
  - InReady=0; no beats are accepted.
  - State, latched_sel and DropCount hold.
  - Output registers continue to drain.
- Busy = (state==BURST).

Test Plan:
- Reset then single beats: Sel=0..7, InData=8'hA0+k, InLast=1, all OutReady=1 -> OutValid[k] pulses 1 cycle after each accept with OutData[k]=8'hA0+k; InReady stays 1; Busy stays 0.
- Backpressure: OutReady[3]=0, send 2 beats to ch3 -> 1st beat held stable on OutValid[3]; InReady=0 on the 2nd beat. Raise OutReady[3] -> drain and reload in the same cycle; both beats delivered in order.
- Burst lock: 4-beat burst with Sel=5 on beat 0, then Sel changed to 2 for beats 1-3, InLast on beat 3 -> all 4 beats on ch5, Busy=1 from after beat 0 until after beat 3. Next beat with Sel=2 routes to ch2.
- Out-of-range drop: CHANNELS=6, Sel=7, 3 beats -> no OutValid asserted, DropCount=3, InReady=1 throughout.
- Enable gating and reset mid-burst: Enable=0 mid-burst -> InReady=0, pending OutValid still drains. Then Rst=1 for 1 cycle -> all outputs 0, Busy=0, DropCount=0; next beat is routed by live Sel.
